sc_stream_sched: RTL and testbench
==================================

SC_STREAM_SCHED -- requirements
Module: sc_stream_sched

Interface
REQ-001 Parameter N, default 8: counter and operand width; every stream is 2^N bits long.
REQ-002 Parameter NREQ, default 4: number of requesters, NREQ >= 2.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port req, input, NREQ: per-requester stream request, held high until done or abort.
REQ-006 Port value, input, NREQ*N: packed operands; slice i holds requester i's binary value.
REQ-007 Port bit_ready, input, 1: the consumer accepts bit_out this cycle.
REQ-008 Port gnt, output, NREQ: one-hot grant; all zeros when no requester is granted.
REQ-009 Port gnt_id, output, $clog2(NREQ): index of the granted requester.
REQ-010 Port bit_out, output, 1: stochastic bit, valid while bit_valid is high.
REQ-011 Port bit_valid, output, 1: high for every cycle in RUN.
REQ-012 Port done, output, 1: one-cycle pulse when a full stream completes.
REQ-013 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The FSM shall have the states IDLE, LOAD, RUN and DONE.
REQ-015 IDLE: if any req bit is high, the block shall pick a winner by round-robin, searching upward from last_gnt+1 with wrap, then move to LOAD.
REQ-016 On the IDLE->LOAD edge, the block shall register gnt, gnt_id and the winner's value slice into op_q.
REQ-017 LOAD: the block shall restart the counter to 0, then move to RUN.
REQ-018 RUN: bit_valid=1 and bit_out = (op_q > cmp), an unsigned N-bit compare, where cmp is the counter output.
REQ-019 RUN: the counter shall advance only in a cycle where bit_valid && bit_ready; otherwise bit_out and cmp hold.
REQ-020 RUN: an accepted bit with counter == 2^N-1 shall move the FSM to DONE; the counter shall wrap to 0.
REQ-021 DONE: done=1 for exactly one cycle, last_gnt <= gnt_id, gnt cleared, then move to IDLE.
REQ-022 Latency: a req seen in IDLE shall give the first bit_valid 2 cycles later, with gnt high from cycle 1.
REQ-023 Abort: if req[gnt_id] falls during LOAD or RUN, the block shall go to IDLE next cycle with no done pulse; gnt and bit_valid shall clear and last_gnt shall update.
REQ-024 Changes to value during LOAD or RUN shall be ignored; op_q is frozen for the whole stream.
REQ-025 Over a complete stream, the number of ones in bit_out shall equal op_q exactly: 0 gives all zeros; 2^N-1 gives all ones but one.
REQ-026 After DONE the FSM shall always pass through IDLE, so back-to-back streams are separated by at least 1 idle cycle.

Reset
REQ-027 While rst=0 the block shall force state=IDLE, counter=0, op_q=0 and last_gnt=NREQ-1, so requester 0 wins first.
REQ-028 While rst=0 the outputs gnt, gnt_id, bit_out, bit_valid, done and busy shall all be 0.
REQ-029 Reset asserted mid-RUN shall abort the stream immediately, with no done pulse.

Configuration
REQ-030 With macro SC_STREAM_SCHED_REVERSE_EN defined, cmp shall be the bit-reversed counter (cmp[i] = count[N-1-i]), giving a spread low-discrepancy stream.
REQ-031 Without SC_STREAM_SCHED_REVERSE_EN, cmp = count directly, giving a unary stream (op_q ones, then zeros).
REQ-032 The ones count of REQ-025 shall hold in both builds.

Structure
REQ-033 Package sc_pkg shall hold the state enum typedef and the default width constants SC_N_DEF=8 and SC_NREQ_DEF=4.
REQ-034 The counter shall be one sub-module, sc_seq_counter, with enable and synchronous restart, wrapping at 2^N-1 and using the same async active-low rst.
REQ-035 The round-robin pick and the compare shall be inline logic in sc_stream_sched.

Verification (N=4, NREQ=4)
REQ-036 Single stream: req=0001, value0=5, bit_ready=1 -> gnt=0001 at cycle 1, 16 bit_valid cycles with 5 ones, done pulse at cycle 18.
REQ-037 Round-robin: req=1111 held, every stream run to completion -> grant order 0,1,2,3,0.
REQ-038 Backpressure: value0=9, bit_ready toggling 1,0 -> exactly 16 accepted bits with 9 ones, and bit_out stable while bit_ready=0.
REQ-039 Extremes: value=0 -> 0 ones; value=15 -> 15 ones. With REVERSE_EN and value=8 -> the pattern 1010... on the first 16 bits.
REQ-040 Abort and reset: drop req0 at bit 6 -> no done and IDLE next cycle; pull rst low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sc_stream_sched_pkg.sv
// Shared types and default widths for the stochastic stream scheduler.
package sc_pkg;

    localparam int SC_N_DEF    = 8;
    localparam int SC_NREQ_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/sc_stream_sched_if.sv
// Requester/consumer bundle of the stream scheduler.
interface sc_stream_sched_if
    import sc_pkg::*;
#(
    parameter int N    = SC_N_DEF,
    parameter int NREQ = SC_NREQ_DEF
) ();

    logic [NREQ-1:0]         req;
    logic [NREQ*N-1:0]       value;
    logic                    bit_ready;
    logic [NREQ-1:0]         gnt;
    logic [$clog2(NREQ)-1:0] gnt_id;
    logic                    bit_out;
    logic                    bit_valid;
    logic                    done;
    logic                    busy;

    modport master (
        output req, value, bit_ready,
        input  gnt, gnt_id, bit_out, bit_valid, done, busy
    );

    modport slave (
        input  req, value, bit_ready,
        output gnt, gnt_id, bit_out, bit_valid, done, busy
    );

endinterface

// File: rtl/sc_stream_sched_counter.sv
// Sequence counter: enable, synchronous restart, natural wrap at 2^N-1.
module sc_seq_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_restart,
    output logic [N-1:0] o_count
);

    logic [N-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + N'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sc_stream_sched.sv
// Round-robin scheduler emitting one 2^N-bit stochastic stream per grant.
// Define SC_STREAM_SCHED_REVERSE_EN to compare against the bit-reversed count.
module sc_stream_sched
    import sc_pkg::*;
#(
    parameter int N    = SC_N_DEF,
    parameter int NREQ = SC_NREQ_DEF
) (
    input logic              clk,
    input logic              rst,
    sc_stream_sched_if.slave s
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    logic [N-1:0]    r_op;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_id;
    logic [NREQ-1:0] r_gnt;
    logic            r_valid;
    logic            r_done;
    logic            r_busy;

    logic [N-1:0]    w_cnt;
    logic [N-1:0]    w_cmp;
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_abort;
    logic            w_acc;
    logic            w_end;
    logic            w_restart;

    // First requester found walking upward from the last grant, with wrap.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = int'(r_last) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!w_any && s.req[j]) begin
                w_any = 1'b1;
                w_win = IW'(j);
            end
        end
    end

    assign w_abort   = !s.req[r_id];
    assign w_acc     = r_valid && s.bit_ready;
    assign w_end     = w_acc && (&w_cnt);
    assign w_restart = (r_state == S_LOAD);

    sc_seq_counter #(.N(N)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_acc),
        .i_restart (w_restart),
        .o_count   (w_cnt)
    );

`ifdef SC_STREAM_SCHED_REVERSE_EN
    for (genvar i = 0; i < N; i++) begin : g_rev
        assign w_cmp[i] = w_cnt[N-1-i];
    end
`else
    assign w_cmp = w_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_last  <= IW'(NREQ - 1);
            r_id    <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_LOAD;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_id    <= w_win;
                        r_op    <= s.value[int'(w_win)*N +: N];
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD, S_RUN: begin
                    // A dropped request ends the stream silently.
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_last  <= r_id;
                        r_id    <= '0;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_state == S_LOAD) begin
                        r_state <= S_RUN;
                        r_valid <= 1'b1;
                    end else if (w_end) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_last  <= r_id;
                    r_id    <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s.gnt       = r_gnt;
    assign s.gnt_id    = r_id;
    assign s.bit_valid = r_valid;
    assign s.bit_out   = r_valid && (r_op > w_cmp);
    assign s.done      = r_done;
    assign s.busy      = r_busy;

endmodule

// File: tb/tb_sc_stream_sched.sv
// Randomised bench for sc_stream_sched (N=4, NREQ=4) against a stream model.
module tb_sc_stream_sched;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   m_last;
    logic [3:0] vals [4];

    sc_stream_sched_if #(.N(4), .NREQ(4)) bus ();

    sc_stream_sched #(.N(4), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] cmp_of(input int k);
        logic [3:0] c;
        logic [3:0] r;
        c = 4'(k);
        for (int i = 0; i < 4; i++) r[i] = c[3-i];
`ifdef SC_STREAM_SCHED_REVERSE_EN
        return r;
`else
        return c;
`endif
    endfunction

    function automatic logic [15:0] exp_bits(input logic [3:0] v);
        logic [15:0] b;
        for (int k = 0; k < 16; k++) b[k] = (v > cmp_of(k));
        return b;
    endfunction

    function automatic int rr_pick(input logic [3:0] rq, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (rq[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic load_vals();
        bus.value = {vals[3], vals[2], vals[1], vals[0]};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = '0;
        bus.bit_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_last = 3;
    endtask

    // Called on the negedge where the FSM idles with req already driven.
    // mode 0: always ready, 1: alternate 1,0 per valid cycle, 2: random.
    task automatic collect(
        input  int          mode,
        input  bit          scramble,
        output logic [3:0]  g1,
        output logic [1:0]  id1,
        output logic        busy1,
        output int          first_v,
        output int          nacc,
        output int          nones,
        output logic [15:0] bits,
        output int          done_cyc,
        output int          hold_err
    );
        int   vcnt;
        bit   pv;
        bit   pr;
        logic pb;
        logic rdy;
        g1 = 'x; id1 = 'x; busy1 = 'x;
        first_v = -1; nacc = 0; nones = 0; bits = '0;
        done_cyc = -1; hold_err = 0; vcnt = 0; pv = 0; pr = 0; pb = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                g1 = bus.gnt; id1 = bus.gnt_id; busy1 = bus.busy;
            end
            if (scramble) bus.value = 16'($urandom);
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            unique case (mode)
                0: rdy = 1'b1;
                1: rdy = (vcnt % 2 == 0);
                default: rdy = ($urandom_range(3) != 0);
            endcase
            bus.bit_ready = rdy;
            if (bus.bit_valid) begin
                if (first_v < 0) first_v = cyc;
                if (pv && !pr && bus.bit_out !== pb) hold_err++;
                if (rdy) begin
                    if (nacc < 16) bits[nacc] = bus.bit_out;
                    nones += int'(bus.bit_out);
                    nacc++;
                end
                pv = 1; pr = rdy; pb = bus.bit_out; vcnt++;
            end else begin
                pv = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '0; bus.value = '0; bus.bit_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.gnt, bus.gnt_id, bus.bit_out, bus.bit_valid, bus.done, bus.busy} !== 10'b0) begin
            $display("FAIL reset_outs: got %b exp 0",
                     {bus.gnt, bus.gnt_id, bus.bit_out, bus.bit_valid, bus.done, bus.busy});
            n_fail++;
        end
        rst = 1'b1;
        m_last = 3;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset_idle_busy: got %b exp 0", bus.busy);
            n_fail++;
        end
    endtask

    task automatic test_single();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he;
        vals = '{4'd5, 4'd0, 4'd0, 4'd0};
        load_vals();
        bus.req = 4'b0001;
        collect(0, 0, g1, id1, b1, fv, na, no, bits, dc, he);
        bus.req = '0;
        n_tests++;
        if (g1 !== 4'b0001 || id1 !== 2'd0 || b1 !== 1'b1) begin
            $display("FAIL single_gnt: got gnt=%b id=%0d busy=%b exp 0001/0/1", g1, id1, b1);
            n_fail++;
        end
        n_tests++;
        if (fv !== 2) begin
            $display("FAIL single_first_valid: got %0d exp 2", fv);
            n_fail++;
        end
        n_tests++;
        if (na !== 16 || no !== 5) begin
            $display("FAIL single_count: got acc=%0d ones=%0d exp 16/5", na, no);
            n_fail++;
        end
        n_tests++;
        if (bits !== exp_bits(4'd5)) begin
            $display("FAIL single_bits: got %h exp %h", bits, exp_bits(4'd5));
            n_fail++;
        end
        n_tests++;
        if (dc !== 18) begin
            $display("FAIL single_done_cycle: got %0d exp 18", dc);
            n_fail++;
        end
        m_last = 0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gnt !== 4'b0) begin
            $display("FAIL single_after: got busy=%b done=%b gnt=%b exp 0/0/0",
                     bus.busy, bus.done, bus.gnt);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he, ex;
        do_reset();
        for (int i = 0; i < 4; i++) vals[i] = 4'($urandom);
        load_vals();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ex = rr_pick(4'b1111, m_last);
            collect(0, 0, g1, id1, b1, fv, na, no, bits, dc, he);
            n_tests++;
            if (int'(id1) !== ex || g1 !== 4'(1) << ex) begin
                $display("FAIL rr_grant_%0d: got id=%0d gnt=%b exp id=%0d", k, id1, g1, ex);
                n_fail++;
            end
            n_tests++;
            if (no !== int'(vals[ex]) || dc < 0) begin
                $display("FAIL rr_ones_%0d: got %0d done=%0d exp %0d", k, no, dc, vals[ex]);
                n_fail++;
            end
            m_last = ex;
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0) begin
                $display("FAIL rr_idle_gap_%0d: got busy=%b exp 0", k, bus.busy);
                n_fail++;
            end
        end
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he;
        vals = '{4'd9, 4'd0, 4'd0, 4'd0};
        load_vals();
        bus.req = 4'b0001;
        collect(1, 0, g1, id1, b1, fv, na, no, bits, dc, he);
        bus.req = '0;
        m_last = 0;
        n_tests++;
        if (na !== 16 || no !== 9 || dc < 0) begin
            $display("FAIL bp_count: got acc=%0d ones=%0d done=%0d exp 16/9/seen", na, no, dc);
            n_fail++;
        end
        n_tests++;
        if (he !== 0) begin
            $display("FAIL bp_hold: got %0d changes exp 0", he);
            n_fail++;
        end
        n_tests++;
        if (bits !== exp_bits(4'd9)) begin
            $display("FAIL bp_bits: got %h exp %h", bits, exp_bits(4'd9));
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he;
        logic [3:0] tv [3];
        logic [15:0] pat8;
`ifdef SC_STREAM_SCHED_REVERSE_EN
        pat8 = 16'h5555;
`else
        pat8 = 16'h00ff;
`endif
        tv = '{4'd0, 4'd15, 4'd8};
        for (int t = 0; t < 3; t++) begin
            vals = '{tv[t], 4'd3, 4'd3, 4'd3};
            load_vals();
            bus.req = 4'b0001;
            collect(0, 0, g1, id1, b1, fv, na, no, bits, dc, he);
            bus.req = '0;
            m_last = 0;
            n_tests++;
            if (no !== int'(tv[t]) || bits !== exp_bits(tv[t])) begin
                $display("FAIL extreme_%0d: got ones=%0d bits=%h exp %0d/%h",
                         tv[t], no, bits, tv[t], exp_bits(tv[t]));
                n_fail++;
            end
            if (tv[t] == 4'd8) begin
                n_tests++;
                if (bits !== pat8) begin
                    $display("FAIL extreme_pattern8: got %h exp %h", bits, pat8);
                    n_fail++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he, ex;
        logic [3:0] rq;
        for (int it = 0; it < 20; it++) begin
            rq = 4'($urandom_range(15, 1));
            for (int i = 0; i < 4; i++) vals[i] = 4'($urandom);
            load_vals();
            bus.req = rq;
            ex = rr_pick(rq, m_last);
            collect(2, 1, g1, id1, b1, fv, na, no, bits, dc, he);
            bus.req = '0;
            n_tests++;
            if (int'(id1) !== ex || na !== 16 || dc < 0 || he !== 0
                || bits !== exp_bits(vals[ex])) begin
                $display("FAIL random_%0d: got id=%0d acc=%0d done=%0d hold=%0d bits=%h exp id=%0d bits=%h",
                         it, id1, na, dc, he, bits, ex, exp_bits(vals[ex]));
                n_fail++;
            end
            m_last = ex;
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int acc;
        int ndone;
        bit dropped;
        vals = '{4'd10, 4'd1, 4'd2, 4'd3};
        load_vals();
        bus.req = 4'b0001;
        bus.bit_ready = 1'b1;
        acc = 0; ndone = 0; dropped = 0;
        for (int c = 0; c < 60 && !dropped; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.bit_valid) acc++;
            if (acc == 6) begin
                bus.req = '0;
                dropped = 1;
            end
        end
        @(negedge clk);
        n_tests++;
        if (!dropped || bus.bit_valid !== 1'b0 || bus.gnt !== 4'b0
            || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL abort_run: got valid=%b gnt=%b busy=%b done=%b exp all 0",
                     bus.bit_valid, bus.gnt, bus.busy, bus.done);
            n_fail++;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin
            $display("FAIL abort_no_done: got %0d pulses exp 0", ndone);
            n_fail++;
        end
        m_last = 0;
        bus.req = 4'b1111;
        @(negedge clk);
        n_tests++;
        if (int'(bus.gnt_id) !== rr_pick(4'b1111, m_last)) begin
            $display("FAIL abort_last_gnt: got %0d exp %0d", bus.gnt_id, rr_pick(4'b1111, m_last));
            n_fail++;
        end
        m_last = int'(rr_pick(4'b1111, m_last));
        bus.req = '0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
            $display("FAIL abort_load: got busy=%b gnt=%b exp 0/0000", bus.busy, bus.gnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g1; logic [1:0] id1; logic b1; logic [15:0] bits;
        int fv, na, no, dc, he, vc;
        vals = '{4'd7, 4'd4, 4'd4, 4'd4};
        load_vals();
        bus.req = 4'b0001;
        bus.bit_ready = 1'b1;
        vc = 0;
        for (int c = 0; c < 40 && vc < 5; c++) begin
            @(negedge clk);
            if (bus.bit_valid) vc++;
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (vc !== 5 || {bus.gnt, bus.gnt_id, bus.bit_out, bus.bit_valid, bus.done, bus.busy} !== 10'b0) begin
            $display("FAIL reset_mid_run: got vc=%0d outs=%b exp 5/0", vc,
                     {bus.gnt, bus.gnt_id, bus.bit_out, bus.bit_valid, bus.done, bus.busy});
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        m_last = 3;
        bus.req = 4'b1111;
        collect(0, 0, g1, id1, b1, fv, na, no, bits, dc, he);
        bus.req = '0;
        n_tests++;
        if (id1 !== 2'd0 || no !== 7 || dc !== 18) begin
            $display("FAIL reset_rr_restart: got id=%0d ones=%0d done=%0d exp 0/7/18", id1, no, dc);
            n_fail++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_last  = 3;
        rst = 1'b0;
        bus.req = '0;
        bus.value = '0;
        bus.bit_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_random();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
